// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller in front of the ALU: decodes funct3/funct7 into a
// 4-bit ALU opcode, drives registered operands, waits ALU_LATENCY cycles, then
// captures the ALU result and presents it on a valid/ready result channel.
module alu_issue_ctrl #(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    // Issue channel
    input  logic        iss_valid,
    output logic        iss_ready,
    input  logic [1:0]  iss_class,
    input  logic [2:0]  iss_funct3,
    input  logic        iss_funct7b5,
    input  logic [31:0] iss_rs1,
    input  logic [31:0] iss_rs2,
    input  logic [31:0] iss_imm,
    // ALU interface
    output logic [31:0] alu_input_a,
    output logic [31:0] alu_input_b,
    output logic [3:0]  alu_opcode,
    input  logic [31:0] alu_output,
    input  logic        alu_neg,
    input  logic        alu_zero,
    // Result channel
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_branch,
    output logic        res_taken,
    output logic        res_illegal
);

    localparam int unsigned CntW = 4;

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpAnd  = 4'b0010;
    localparam logic [3:0] OpOr   = 4'b0011;
    localparam logic [3:0] OpXor  = 4'b0100;
    localparam logic [3:0] OpSll  = 4'b0101;
    localparam logic [3:0] OpSrl  = 4'b0110;
    localparam logic [3:0] OpSra  = 4'b0111;
    localparam logic [3:0] OpSlt  = 4'b1000;
    localparam logic [3:0] OpSltu = 4'b1001;

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [3:0]        op_q, op_d;
    logic [31:0]       data_q, data_d;
    logic              branch_q, branch_d;
    logic              taken_q, taken_d;
    logic              illegal_q, illegal_d;
    // Branch sense: taken = zero ^ inv
    logic              inv_q, inv_d;

    logic [3:0]        dec_op;
    logic              dec_illegal;
    logic              dec_branch;
    logic              dec_inv;

    // Sign flag is reserved for status and not consumed here.
    logic unused_alu_neg;
    assign unused_alu_neg = alu_neg;

    // Decode class/funct3/funct7b5 into ALU opcode, branch sense and legality.
    always_comb begin
        dec_op      = OpAdd;
        dec_illegal = 1'b0;
        dec_branch  = 1'b0;
        dec_inv     = 1'b0;
        unique case (iss_class)
            2'b00, 2'b01: begin
                unique case (iss_funct3)
                    3'b000: dec_op = (iss_class == 2'b00 && iss_funct7b5) ? OpSub : OpAdd;
                    3'b001: dec_op = OpSll;
                    3'b010: dec_op = OpSlt;
                    3'b011: dec_op = OpSltu;
                    3'b100: dec_op = OpXor;
                    3'b101: dec_op = iss_funct7b5 ? OpSra : OpSrl;
                    3'b110: dec_op = OpOr;
                    3'b111: dec_op = OpAnd;
                    default: dec_op = OpAdd;
                endcase
                if (iss_class == 2'b00) begin
                    dec_illegal = iss_funct7b5 && (iss_funct3 != 3'b000) && (iss_funct3 != 3'b101);
                end else begin
                    dec_illegal = iss_funct7b5 && (iss_funct3 == 3'b001);
                end
            end
            2'b10: begin
                dec_branch = 1'b1;
                unique case (iss_funct3)
                    3'b000: begin dec_op = OpSub;  dec_inv = 1'b0; end
                    3'b001: begin dec_op = OpSub;  dec_inv = 1'b1; end
                    3'b100: begin dec_op = OpSlt;  dec_inv = 1'b1; end
                    3'b101: begin dec_op = OpSlt;  dec_inv = 1'b0; end
                    3'b110: begin dec_op = OpSltu; dec_inv = 1'b1; end
                    3'b111: begin dec_op = OpSltu; dec_inv = 1'b0; end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Next-state and register updates for the IDLE/WAIT/HOLD sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        data_d    = data_q;
        branch_d  = branch_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        inv_d     = inv_q;
        unique case (state_q)
            StIdle: begin
                if (iss_valid) begin
                    illegal_d = dec_illegal;
                    branch_d  = dec_branch && !dec_illegal;
                    taken_d   = 1'b0;
                    inv_d     = dec_inv;
                    state_d   = StWait;
                    if (dec_illegal) begin
                        // No ALU traffic; a zero count makes res_valid rise one edge later.
                        data_d = 32'd0;
                        cnt_d  = '0;
                    end else begin
                        a_d   = iss_rs1;
                        b_d   = (iss_class == 2'b01) ? iss_imm : iss_rs2;
                        op_d  = dec_op;
                        cnt_d = CntW'(ALU_LATENCY - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    if (!illegal_q) begin
                        data_d  = alu_output;
                        taken_d = branch_q && (alu_zero ^ inv_q);
                    end
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            op_q      <= 4'd0;
            data_q    <= 32'd0;
            branch_q  <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            data_q    <= data_d;
            branch_q  <= branch_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            inv_q     <= inv_d;
        end
    end

    // Handshake and data outputs; iss_ready is masked while reset is held.
    always_comb begin
        iss_ready   = (state_q == StIdle) && !rst;
        res_valid   = (state_q == StHold);
        alu_input_a = a_q;
        alu_input_b = b_q;
        alu_opcode  = op_q;
        res_data    = data_q;
        res_branch  = branch_q;
        res_taken   = taken_q;
        res_illegal = illegal_q;
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (ALU_LATENCY 1 and 3), a behavioural ALU,
// a spec-level model compared every cycle, and directed vectors with literal checks.
module tb_alu_issue_ctrl;

    typedef struct packed {
        logic        ill;
        logic        br;
        logic        taken;
        logic [3:0]  op;
        logic [31:0] data;
        logic [31:0] b;
    } exp_t;

    logic        clk;
    logic        rst          [2];
    logic        iss_valid    [2];
    logic        iss_ready    [2];
    logic [1:0]  iss_class    [2];
    logic [2:0]  iss_funct3   [2];
    logic        iss_funct7b5 [2];
    logic [31:0] iss_rs1      [2];
    logic [31:0] iss_rs2      [2];
    logic [31:0] iss_imm      [2];
    logic [31:0] alu_a        [2];
    logic [31:0] alu_b        [2];
    logic [3:0]  alu_op       [2];
    logic [31:0] alu_out      [2];
    logic        alu_neg      [2];
    logic        alu_zero     [2];
    logic        res_valid    [2];
    logic        res_ready    [2];
    logic [31:0] res_data     [2];
    logic        res_branch   [2];
    logic        res_taken    [2];
    logic        res_illegal  [2];

    int n_vec  = 0;
    int n_miss = 0;

    // Model state
    longint ecnt = 0;
    int     phase    [2];   // 0 idle, 1 busy, 2 presenting
    longint valid_at [2];
    exp_t   cur      [2];
    logic [31:0] ea  [2];
    logic [31:0] eb  [2];
    logic [3:0]  eop [2];

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return 32'($signed(a) >>> b[4:0]);
            4'd8: return {31'd0, $signed(a) < $signed(b)};
            4'd9: return {31'd0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // RISC-V level expectation: opcode choice, legality, branch outcome by comparison.
    function automatic exp_t ref_op(input logic [1:0] cls, input logic [2:0] f3, input logic b5,
                                    input logic [31:0] rs1, input logic [31:0] rs2,
                                    input logic [31:0] imm);
        exp_t e;
        e = '0;
        e.b = (cls == 2'b01) ? imm : rs2;
        if (cls == 2'b10) begin
            e.br = 1'b1;
            case (f3)
                3'b000: begin e.op = 4'd1; e.taken = (rs1 == rs2); end
                3'b001: begin e.op = 4'd1; e.taken = (rs1 != rs2); end
                3'b100: begin e.op = 4'd8; e.taken = ($signed(rs1) < $signed(rs2)); end
                3'b101: begin e.op = 4'd8; e.taken = ($signed(rs1) >= $signed(rs2)); end
                3'b110: begin e.op = 4'd9; e.taken = (rs1 < rs2); end
                3'b111: begin e.op = 4'd9; e.taken = (rs1 >= rs2); end
                default: e.ill = 1'b1;
            endcase
        end else if (cls == 2'b11) begin
            e.ill = 1'b1;
        end else begin
            case (f3)
                3'b000: e.op = (cls == 2'b00 && b5) ? 4'd1 : 4'd0;
                3'b001: e.op = 4'd5;
                3'b010: e.op = 4'd8;
                3'b011: e.op = 4'd9;
                3'b100: e.op = 4'd4;
                3'b101: e.op = b5 ? 4'd7 : 4'd6;
                3'b110: e.op = 4'd3;
                default: e.op = 4'd2;
            endcase
            if (cls == 2'b00) e.ill = b5 && (f3 != 3'b000) && (f3 != 3'b101);
            else              e.ill = b5 && (f3 == 3'b001);
        end
        if (e.ill) begin
            e.br    = 1'b0;
            e.taken = 1'b0;
            e.data  = 32'd0;
        end else begin
            e.data = alu_fn(e.op, rs1, e.b);
        end
        return e;
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s[%0d]: got %h, want %h", name, i, act, exp);
        end
    endtask

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            alu_issue_ctrl #(
                .ALU_LATENCY(g == 0 ? 1 : 3)
            ) u_dut (
                .clk         (clk),
                .rst         (rst[g]),
                .iss_valid   (iss_valid[g]),
                .iss_ready   (iss_ready[g]),
                .iss_class   (iss_class[g]),
                .iss_funct3  (iss_funct3[g]),
                .iss_funct7b5(iss_funct7b5[g]),
                .iss_rs1     (iss_rs1[g]),
                .iss_rs2     (iss_rs2[g]),
                .iss_imm     (iss_imm[g]),
                .alu_input_a (alu_a[g]),
                .alu_input_b (alu_b[g]),
                .alu_opcode  (alu_op[g]),
                .alu_output  (alu_out[g]),
                .alu_neg     (alu_neg[g]),
                .alu_zero    (alu_zero[g]),
                .res_valid   (res_valid[g]),
                .res_ready   (res_ready[g]),
                .res_data    (res_data[g]),
                .res_branch  (res_branch[g]),
                .res_taken   (res_taken[g]),
                .res_illegal (res_illegal[g])
            );
            assign alu_out[g]  = alu_fn(alu_op[g], alu_a[g], alu_b[g]);
            assign alu_neg[g]  = alu_out[g][31];
            assign alu_zero[g] = (alu_out[g] == 32'd0);
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model advance on each rising edge
    always @(posedge clk) begin
        ecnt++;
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                phase[i] = 0;
                ea[i]    = 32'd0;
                eb[i]    = 32'd0;
                eop[i]   = 4'd0;
            end else begin
                case (phase[i])
                    0: if (iss_valid[i]) begin
                        cur[i] = ref_op(iss_class[i], iss_funct3[i], iss_funct7b5[i],
                                        iss_rs1[i], iss_rs2[i], iss_imm[i]);
                        if (!cur[i].ill) begin
                            ea[i]  = iss_rs1[i];
                            eb[i]  = cur[i].b;
                            eop[i] = cur[i].op;
                        end
                        valid_at[i] = ecnt + (cur[i].ill ? 1 : lat_of(i));
                        phase[i]    = 1;
                    end
                    1: if (ecnt == valid_at[i]) phase[i] = 2;
                    default: if (res_ready[i]) phase[i] = 0;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check("iss_ready", i, 32'(iss_ready[i]), 32'(!rst[i] && phase[i] == 0));
            check("res_valid", i, 32'(res_valid[i]), 32'(!rst[i] && phase[i] == 2));
            check("alu_input_a", i, alu_a[i], rst[i] ? 32'd0 : ea[i]);
            check("alu_input_b", i, alu_b[i], rst[i] ? 32'd0 : eb[i]);
            check("alu_opcode", i, 32'(alu_op[i]), rst[i] ? 32'd0 : 32'(eop[i]));
            if (rst[i]) begin
                check("rst_res_data", i, res_data[i], 32'd0);
                check("rst_res_flags", i,
                      {29'd0, res_branch[i], res_taken[i], res_illegal[i]}, 32'd0);
            end else if (phase[i] == 2) begin
                check("res_data", i, res_data[i], cur[i].data);
                check("res_branch", i, 32'(res_branch[i]), 32'(cur[i].br));
                check("res_taken", i, 32'(res_taken[i]), 32'(cur[i].taken));
                check("res_illegal", i, 32'(res_illegal[i]), 32'(cur[i].ill));
            end
        end
    end

    // Drive one issue and return just after its accept edge.
    task automatic start(input int i, input logic [1:0] cls, input logic [2:0] f3,
                         input logic b5, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm);
        res_ready[i] = 1'b0;
        @(posedge clk);
        #2;
        iss_class[i]    = cls;
        iss_funct3[i]   = f3;
        iss_funct7b5[i] = b5;
        iss_rs1[i]      = rs1;
        iss_rs2[i]      = rs2;
        iss_imm[i]      = imm;
        iss_valid[i]    = 1'b1;
        @(posedge clk);
        #2;
        // Garbage held on the issue port while busy must be ignored.
        iss_class[i]    = 2'b00;
        iss_funct3[i]   = 3'b000;
        iss_funct7b5[i] = 1'b0;
        iss_rs1[i]      = ~rs1;
        iss_rs2[i]      = 32'h5555_AAAA;
    endtask

    task automatic do_op(input int i, input logic [1:0] cls, input logic [2:0] f3,
                         input logic b5, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input int stall, output int lat,
                         output logic [31:0] data, output logic [3:0] op,
                         output logic br, output logic taken, output logic ill);
        start(i, cls, f3, b5, rs1, rs2, imm);
        lat = 0;
        op  = 4'hx;
        forever begin
            @(negedge clk);
            if (lat == 0) op = alu_op[i];
            if (res_valid[i] || lat >= 40) break;
            @(posedge clk);
            lat++;
        end
        data  = res_data[i];
        br    = res_branch[i];
        taken = res_taken[i];
        ill   = res_illegal[i];
        repeat (stall) @(negedge clk);
        @(posedge clk);
        #2;
        iss_valid[i] = 1'b0;
        res_ready[i] = 1'b1;
        @(posedge clk);
        #2;
        res_ready[i] = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] data;
        logic [3:0]  op;
        logic        br, taken, ill;
        int          seen;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            iss_valid[i] = 1'b0;
            iss_class[i] = 2'b00;
            iss_funct3[i] = 3'b000;
            iss_funct7b5[i] = 1'b0;
            iss_rs1[i] = 32'd0;
            iss_rs2[i] = 32'd0;
            iss_imm[i] = 32'd0;
            res_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #2;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        check("lit_ready_after_reset", 0, 32'(iss_ready[0]), 32'd1);

        // ADD 5+7
        do_op(0, 2'b00, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 0, lat, data, op, br, taken, ill);
        check("lit_add_lat", 0, lat, 1);
        check("lit_add_op", 0, 32'(op), 32'h0);
        check("lit_add_data", 0, data, 32'd12);
        check("lit_add_branch", 0, 32'(br), 32'd0);

        // SUB 3-5, consumer stalls 3 cycles
        do_op(0, 2'b00, 3'b000, 1'b1, 32'd3, 32'd5, 32'd0, 3, lat, data, op, br, taken, ill);
        check("lit_sub_op", 0, 32'(op), 32'h1);
        check("lit_sub_data", 0, data, 32'hFFFF_FFFE);

        // BLT -1 < 1
        do_op(0, 2'b10, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, lat, data, op, br, taken,
              ill);
        check("lit_blt_op", 0, 32'(op), 32'h8);
        check("lit_blt_taken", 0, 32'(taken), 32'd1);
        check("lit_blt_branch", 0, 32'(br), 32'd1);

        // BGEU 0xFFFFFFFF >= 1
        do_op(0, 2'b10, 3'b111, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, lat, data, op, br, taken,
              ill);
        check("lit_bgeu_op", 0, 32'(op), 32'h9);
        check("lit_bgeu_taken", 0, 32'(taken), 32'd1);

        // BEQ equal
        do_op(0, 2'b10, 3'b000, 1'b0, 32'h1234, 32'h1234, 32'd0, 0, lat, data, op, br, taken,
              ill);
        check("lit_beq_taken", 0, 32'(taken), 32'd1);

        // BNE equal -> not taken
        do_op(0, 2'b10, 3'b001, 1'b0, 32'h1234, 32'h1234, 32'd0, 0, lat, data, op, br, taken,
              ill);
        check("lit_bne_taken", 0, 32'(taken), 32'd0);

        // SRAI by immediate 4
        do_op(0, 2'b01, 3'b101, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd4, 0, lat, data, op,
              br, taken, ill);
        check("lit_srai_op", 0, 32'(op), 32'h7);
        check("lit_srai_data", 0, data, 32'hF800_0000);

        // ADDI with b5 set stays ADD
        do_op(0, 2'b01, 3'b000, 1'b1, 32'd10, 32'd99, 32'hFFFF_FFFF, 0, lat, data, op, br,
              taken, ill);
        check("lit_addi_data", 0, data, 32'd9);

        // Illegal reg-reg XOR with b5: ALU port keeps previous ADDI values
        do_op(0, 2'b00, 3'b100, 1'b1, 32'hDEAD, 32'hBEEF, 32'd0, 2, lat, data, op, br, taken,
              ill);
        check("lit_ill_lat", 0, lat, 1);
        check("lit_ill_flag", 0, 32'(ill), 32'd1);
        check("lit_ill_data", 0, data, 32'd0);
        check("lit_ill_op_kept", 0, 32'(op), 32'h0);
        check("lit_ill_a_kept", 0, alu_a[0], 32'd10);

        // Illegal class 11
        do_op(0, 2'b11, 3'b000, 1'b0, 32'h1, 32'h2, 32'h3, 0, lat, data, op, br, taken, ill);
        check("lit_cls3_lat", 0, lat, 1);
        check("lit_cls3_flag", 0, 32'(ill), 32'd1);
        check("lit_cls3_data", 0, data, 32'd0);

        // Illegal branch funct3 010, and SLLI with b5
        do_op(0, 2'b10, 3'b010, 1'b0, 32'h1, 32'h2, 32'h3, 0, lat, data, op, br, taken, ill);
        check("lit_br010_flag", 0, 32'(ill), 32'd1);
        do_op(0, 2'b01, 3'b001, 1'b1, 32'h1, 32'h2, 32'h3, 0, lat, data, op, br, taken, ill);
        check("lit_slli_b5_flag", 0, 32'(ill), 32'd1);

        // Latency 3 instance
        do_op(1, 2'b00, 3'b000, 1'b0, 32'd100, 32'd23, 32'd0, 0, lat, data, op, br, taken, ill);
        check("lit_l3_lat", 1, lat, 3);
        check("lit_l3_data", 1, data, 32'd123);
        do_op(1, 2'b00, 3'b110, 1'b0, 32'hF0F0, 32'h0F0F, 32'd0, 1, lat, data, op, br, taken,
              ill);
        check("lit_l3_or_data", 1, data, 32'hFFFF);

        // Reset pulsed during WAIT discards the operation
        start(1, 2'b00, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0);
        iss_valid[1] = 1'b0;
        @(posedge clk);
        #2;
        rst[1] = 1'b1;
        @(negedge clk);
        check("lit_rst_ready", 1, 32'(iss_ready[1]), 32'd0);
        check("lit_rst_a", 1, alu_a[1], 32'd0);
        @(posedge clk);
        #2;
        rst[1] = 1'b0;
        @(negedge clk);
        check("lit_rst_release_ready", 1, 32'(iss_ready[1]), 32'd1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (res_valid[1]) seen++;
        end
        check("lit_rst_no_valid", 1, seen, 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
